// File: rtl/inst_encode_loader.sv
// inst_encode_loader: packs RV32I instruction fields into 32-bit words and streams them
// to consecutive instruction-memory addresses, one word per accepted field set.
module inst_encode_loader #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    input  logic [6:0]                   opcode,
    input  logic [2:0]                   func3,
    input  logic [6:0]                   func7,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    input  logic [31:0]                  imm,
    output logic                         imem_we,
    output logic [ADDR_W-1:0]            imem_addr,
    output logic [31:0]                  imem_wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         err_illegal,
    output logic                         err_full,
    output logic [$clog2(DEPTH+1)-1:0]   word_count
);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;

    logic [ADDR_W-1:0] addr;
    logic [31:0] enc, enc_i;
    logic legal, hs, restart, full_hit;

    assign in_ready = (state == RUN);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign hs       = in_valid & in_ready;
    assign restart  = start & (state != RUN);
    assign full_hit = hs & legal & (word_count == CW'(DEPTH-1));
    assign enc_i    = {imm[11:0], rs1, func3, rd, opcode};

    always_comb begin
        legal = 1'b1;
        enc   = '0;
        case (opcode)
            7'b0110011: enc = {func7, rs2, rs1, func3, rd, opcode};
            // shift-immediates carry func7 in the upper bits and only a 5-bit shamt
            7'b0010011: enc = (func3 == 3'b001 || func3 == 3'b101) ?
                              {func7, imm[4:0], rs1, func3, rd, opcode} : enc_i;
            7'b0000011, 7'b1100111: enc = enc_i;
            7'b0100011: enc = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
            7'b1100011: enc = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
            7'b0110111, 7'b0010111: enc = {imm[31:12], rd, opcode};
            7'b1101111: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            RUN:     state_n = (hs && (in_last || full_hit)) ? DONE : RUN;
            default: state_n = start ? RUN : state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr        <= BASE_ADDR;
            word_count  <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (restart) begin
                addr        <= BASE_ADDR;
                word_count  <= '0;
                err_illegal <= 1'b0;
                err_full    <= 1'b0;
            end else if (hs) begin
                if (legal) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= addr;
                    imem_wdata <= enc;
                    addr       <= addr + ADDR_W'(4);
                    word_count <= word_count + CW'(1);
                end
                if (!legal) err_illegal <= 1'b1;
                if (full_hit && !in_last) err_full <= 1'b1;
            end
        end
    end
endmodule
